// File: rtl/fabric_pkg.sv
// Shared flit encodings, LFSR constants and FSM state types
// for the packet fabric node.
package fabric_pkg;

    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;
    localparam logic [1:0] FLIT_RSVD = 2'b11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HEAD,
        TX_BODY,
        TX_TAIL,
        TX_DONE
    } tx_state_t;

    typedef enum logic {
        RX_WAIT_HEAD,
        RX_IN_PKT
    } rx_state_t;

    function automatic int flit_w(input int data_size);
        return data_size + 2;
    endfunction

endpackage

// File: rtl/fabric_lfsr.sv
// 16-bit Fibonacci LFSR, reloaded from i_seed while reset is high
// and stepping once per clock otherwise.
module fabric_lfsr
    import fabric_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb    = ^(r_lfsr & LFSR_TAPS);
    assign o_state = r_lfsr;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_lfsr <= i_seed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

endmodule

// File: rtl/fabric.sv
// Fabric node: generates random packets to peer nodes and
// checks/counts the packets it receives.
module fabric
    import fabric_pkg::*;
#(
    parameter int DATA_SIZE    = 4,
    parameter int ADDR_SIZE    = 1,
    parameter int ADDR         = 0,
    parameter int NODES_NUM    = 2,
    parameter int PACKS_TO_GEN = 10,
    parameter int MAX_PACK_LEN = 10,
    parameter int DEBUG        = 0
) (
    input  logic                         clk,
    input  logic                         a_rst,
    input  logic [flit_w(DATA_SIZE)-1:0] data_i,
    input  logic                         in_w,
    output logic                         in_r,
    output logic [flit_w(DATA_SIZE)-1:0] data_o,
    output logic                         out_w,
    input  logic                         out_r
);

    localparam int FW = flit_w(DATA_SIZE);
    localparam int CW = DATA_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] SRC = ADDR_SIZE'(ADDR);

    logic [15:0] w_lfsr;

    fabric_lfsr u_lfsr (
        .clk     (clk),
        .i_rst   (a_rst),
        .i_seed  (LFSR_SEED ^ 16'(ADDR)),
        .o_state (w_lfsr)
    );

    // ---------------- generator ----------------
    tx_state_t            r_tx_state;
    tx_state_t            w_tx_next;
    logic [FW-1:0]        r_data_o;
    logic [FW-1:0]        w_data_nxt;
    logic [DATA_SIZE-1:0] r_len;
    logic [DATA_SIZE-1:0] w_len_calc;
    logic [DATA_SIZE-1:0] r_body_cnt;
    logic [DATA_SIZE-1:0] w_body_nxt;
    logic [ADDR_SIZE-1:0] w_dest_calc;
    logic [DATA_SIZE-1:0] w_head_pl;
    logic [15:0]          r_sent_cnt;
    logic                 w_tx_fire;
    logic                 w_len_ld;
    logic                 w_sent;

    assign w_len_calc = DATA_SIZE'(
        16'd2 + (w_lfsr % 16'(MAX_PACK_LEN - 1)));
    // offset 1..NODES_NUM-1 from our own address, so never ourselves
    assign w_dest_calc = ADDR_SIZE'(
        (ADDR + 1 + int'(w_lfsr[15:8]) % (NODES_NUM - 1))
        % NODES_NUM);

    assign out_w = (r_tx_state == TX_HEAD) ||
                   (r_tx_state == TX_BODY) ||
                   (r_tx_state == TX_TAIL);
    assign data_o    = r_data_o;
    assign w_tx_fire = out_w & out_r;

    always_comb begin
        w_tx_next  = r_tx_state;
        w_data_nxt = r_data_o;
        w_body_nxt = r_body_cnt;
        w_len_ld   = 1'b0;
        w_sent     = 1'b0;
        w_head_pl  = '0;
        w_head_pl[ADDR_SIZE-1:0]           = w_dest_calc;
        w_head_pl[2*ADDR_SIZE-1:ADDR_SIZE] = SRC;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (r_sent_cnt >= 16'(PACKS_TO_GEN)) begin
                    w_tx_next = TX_DONE;
                end else begin
                    w_tx_next  = TX_HEAD;
                    w_data_nxt = {FLIT_HEAD, w_head_pl};
                    w_len_ld   = 1'b1;
                end
            end
            TX_HEAD: begin
                if (w_tx_fire) begin
                    w_body_nxt = '0;
                    if (r_len == DATA_SIZE'(2)) begin
                        w_tx_next  = TX_TAIL;
                        w_data_nxt = {FLIT_TAIL, r_len};
                    end else begin
                        w_tx_next  = TX_BODY;
                        w_data_nxt = {FLIT_BODY,
                                      w_lfsr[DATA_SIZE-1:0]};
                    end
                end
            end
            TX_BODY: begin
                if (w_tx_fire) begin
                    w_body_nxt = r_body_cnt + 1'b1;
                    if (w_body_nxt == r_len - DATA_SIZE'(2)) begin
                        w_tx_next  = TX_TAIL;
                        w_data_nxt = {FLIT_TAIL, r_len};
                    end else begin
                        w_data_nxt = {FLIT_BODY,
                                      w_lfsr[DATA_SIZE-1:0]};
                    end
                end
            end
            TX_TAIL: begin
                if (w_tx_fire) begin
                    w_sent     = 1'b1;
                    w_data_nxt = '0;
                    if (r_sent_cnt == 16'(PACKS_TO_GEN - 1)) begin
                        w_tx_next = TX_DONE;
                    end else begin
                        w_tx_next = TX_IDLE;
                    end
                end
            end
            TX_DONE: begin
                w_tx_next = TX_DONE;
            end
            default: begin
                w_tx_next  = TX_IDLE;
                w_data_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_tx_state <= TX_IDLE;
            r_data_o   <= '0;
            r_len      <= '0;
            r_body_cnt <= '0;
            r_sent_cnt <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            r_data_o   <= w_data_nxt;
            r_body_cnt <= w_body_nxt;
            if (w_len_ld) begin
                r_len <= w_len_calc;
            end
            if (w_sent && r_sent_cnt != 16'hFFFF) begin
                r_sent_cnt <= r_sent_cnt + 16'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t            r_rx_state;
    rx_state_t            w_rx_next;
    logic                 r_in_r;
    logic [CW-1:0]        r_rx_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [CW-1:0]        w_cnt_inc;
    logic                 r_drop;
    logic                 w_drop_nxt;
    logic [1:0]           w_type;
    logic [DATA_SIZE-1:0] w_pl;
    logic                 w_rx_fire;
    logic                 w_over;
    logic                 w_dest_ok;
    logic                 w_rx_ok;
    logic                 w_rx_err;
    logic [15:0]          r_recv_cnt;
    logic [15:0]          r_err_cnt;

    assign in_r      = r_in_r;
    assign w_type    = data_i[FW-1:DATA_SIZE];
    assign w_pl      = data_i[DATA_SIZE-1:0];
    assign w_rx_fire = in_w & r_in_r;
    assign w_cnt_inc = r_rx_cnt + 1'b1;
    assign w_over    = w_cnt_inc > CW'(MAX_PACK_LEN);
    assign w_dest_ok = w_pl[ADDR_SIZE-1:0] == SRC;

    // A misaddressed packet is counted once at its head and the rest
    // of it is swallowed silently (r_drop) up to its tail.
    always_comb begin
        w_rx_next  = r_rx_state;
        w_cnt_nxt  = r_rx_cnt;
        w_drop_nxt = r_drop;
        w_rx_ok    = 1'b0;
        w_rx_err   = 1'b0;
        if (w_rx_fire) begin
            unique case (w_type)
                FLIT_HEAD: begin
                    w_rx_err = ((r_rx_state == RX_IN_PKT) && !r_drop)
                               || !w_dest_ok;
                    w_rx_next  = RX_IN_PKT;
                    w_cnt_nxt  = CW'(1);
                    w_drop_nxt = !w_dest_ok;
                end
                FLIT_BODY: begin
                    if (r_rx_state == RX_WAIT_HEAD) begin
                        w_rx_err = 1'b1;
                    end else if (w_over) begin
                        w_rx_err   = !r_drop;
                        w_rx_next  = RX_WAIT_HEAD;
                        w_cnt_nxt  = '0;
                        w_drop_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                FLIT_TAIL: begin
                    if (r_rx_state == RX_WAIT_HEAD) begin
                        w_rx_err = 1'b1;
                    end else begin
                        w_rx_next  = RX_WAIT_HEAD;
                        w_cnt_nxt  = '0;
                        w_drop_nxt = 1'b0;
                        if (!r_drop) begin
                            if (w_over || {1'b0, w_pl} != w_cnt_inc) begin
                                w_rx_err = 1'b1;
                            end else begin
                                w_rx_ok = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_rx_err   = 1'b1;
                    w_rx_next  = RX_WAIT_HEAD;
                    w_cnt_nxt  = '0;
                    w_drop_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            r_in_r     <= 1'b0;
            r_rx_state <= RX_WAIT_HEAD;
            r_rx_cnt   <= '0;
            r_drop     <= 1'b0;
            r_recv_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_in_r     <= 1'b1;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= w_cnt_nxt;
            r_drop     <= w_drop_nxt;
            if (w_rx_ok && r_recv_cnt != 16'hFFFF) begin
                r_recv_cnt <= r_recv_cnt + 16'd1;
            end
            if (w_rx_err && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    if (DEBUG != 0) begin : g_dbg
        always @(posedge clk) begin
            if (!a_rst && w_sent)
                $display("%0t node %0d: packet sent", $time, ADDR);
            if (!a_rst && w_rx_ok)
                $display("%0t node %0d: packet received", $time, ADDR);
            if (!a_rst && w_rx_err)
                $display("%0t node %0d: receive error", $time, ADDR);
        end
    end

endmodule

// File: tb/tb_fabric.sv
// Directed bench: two cross-connected nodes, then node 0 alone
// driven flit by flit from the bench.
module tb_fabric;
    import fabric_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] d0_i, d1_i, d0_o, d1_o;
    logic       w0_i, w1_i, w0_o, w1_o;
    logic       r0_i, r1_i, r0_o, r1_o;
    logic       xconn;
    logic [5:0] tb_data;
    logic       tb_in_w;
    logic       tb_out_r;
    int         n_chk;
    int         n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign d0_i = xconn ? d1_o : tb_data;
    assign w0_i = xconn ? w1_o : tb_in_w;
    assign r0_i = xconn ? r1_o : tb_out_r;
    assign d1_i = xconn ? d0_o : 6'd0;
    assign w1_i = xconn ? w0_o : 1'b0;
    assign r1_i = xconn ? r0_o : 1'b0;

    fabric #(.ADDR(0)) u_n0 (
        .clk    (clk),
        .a_rst  (rst),
        .data_i (d0_i),
        .in_w   (w0_i),
        .in_r   (r0_o),
        .data_o (d0_o),
        .out_w  (w0_o),
        .out_r  (r0_i)
    );

    fabric #(.ADDR(1)) u_n1 (
        .clk    (clk),
        .a_rst  (rst),
        .data_i (d1_i),
        .in_w   (w1_i),
        .in_r   (r1_o),
        .data_o (d1_o),
        .out_w  (w1_o),
        .out_r  (r1_i)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        rst = 1'b1;
        repeat (cyc) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_flit(input logic [5:0] f);
        @(negedge clk);
        tb_data = f;
        tb_in_w = 1'b1;
        @(negedge clk);
        tb_in_w = 1'b0;
        tb_data = 6'h3F;
    endtask

    initial begin
        int n;
        n_chk    = 0;
        n_fail   = 0;
        xconn    = 1'b1;
        tb_data  = '0;
        tb_in_w  = 1'b0;
        tb_out_r = 1'b0;
        rst      = 1'b1;

        // reset state, then two nodes exchanging traffic
        repeat (2) @(negedge clk);
        chk("rst_out_w", 32'(w0_o), 32'd0);
        chk("rst_data_o", 32'(d0_o), 32'd0);
        chk("rst_in_r", 32'(r0_o), 32'd0);
        chk("rst_in_r1", 32'(r1_o), 32'd0);
        chk("rst_err", 32'(u_n0.r_err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_r", 32'(r0_o), 32'd1);
        repeat (300) @(negedge clk);
        chk("x_sent0", 32'(u_n0.r_sent_cnt), 32'd10);
        chk("x_sent1", 32'(u_n1.r_sent_cnt), 32'd10);
        chk("x_recv0", 32'(u_n0.r_recv_cnt), 32'd10);
        chk("x_recv1", 32'(u_n1.r_recv_cnt), 32'd10);
        chk("x_err0", 32'(u_n0.r_err_cnt), 32'd0);
        chk("x_err1", 32'(u_n1.r_err_cnt), 32'd0);
        chk("x_done_w0", 32'(w0_o), 32'd0);

        // back-pressure: head must hold while out_r is low
        xconn    = 1'b0;
        tb_out_r = 1'b0;
        do_reset(2);
        n = 0;
        while (!w0_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_head_seen", 32'(n < 20), 32'd1);
        chk("bp_head", 32'(d0_o), 32'h11);
        repeat (20) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(d0_o), 32'h11);
            chk("bp_hold_w", 32'(w0_o), 32'd1);
        end

        // body flit with no packet open
        do_reset(2);
        send_flit(6'b00_0101);
        chk("orphan_err", 32'(u_n0.r_err_cnt), 32'd1);
        chk("orphan_state", 32'(u_n0.r_rx_state),
            32'(RX_WAIT_HEAD));
        chk("orphan_recv", 32'(u_n0.r_recv_cnt), 32'd0);

        // head addressed to another node
        do_reset(2);
        send_flit(6'b01_0011);
        send_flit(6'b10_0010);
        chk("dest_err", 32'(u_n0.r_err_cnt), 32'd1);
        chk("dest_recv", 32'(u_n0.r_recv_cnt), 32'd0);

        // wrong tail length, then a good 3-flit packet
        do_reset(2);
        send_flit(6'b01_0010);
        send_flit(6'b00_0101);
        send_flit(6'b10_0100);
        chk("len_err", 32'(u_n0.r_err_cnt), 32'd1);
        chk("len_recv0", 32'(u_n0.r_recv_cnt), 32'd0);
        send_flit(6'b01_0010);
        send_flit(6'b00_0101);
        send_flit(6'b10_0011);
        chk("good_recv", 32'(u_n0.r_recv_cnt), 32'd1);
        chk("good_err", 32'(u_n0.r_err_cnt), 32'd1);
        chk("good_state", 32'(u_n0.r_rx_state),
            32'(RX_WAIT_HEAD));

        // reset while a body flit is on the wire
        do_reset(2);
        tb_out_r = 1'b1;
        n = 0;
        while (!(w0_o && d0_o[5:4] == 2'b00) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abort_body_seen", 32'(n < 300), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_w", 32'(w0_o), 32'd0);
        chk("abort_in_r", 32'(r0_o), 32'd0);
        chk("abort_data_o", 32'(d0_o), 32'd0);
        rst = 1'b0;
        n = 0;
        while (!w0_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_restart", 32'(n < 20), 32'd1);
        chk("abort_first_head", 32'(d0_o), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
